gtech_nand8_match_qual: RTL and testbench
=========================================

// Module: gtech_nand8_match_qual
// PURPOSE
//   Registered qualifier that sits directly downstream of the 8-input NAND.
//   Consumes its active-low "all eight inputs high" output (ZN) and asserts
//   MATCH only after ZN has been low for STABLE_CYCLES consecutive cycles.
//   Deasserts with the same symmetric debounce, emits a one-cycle RISE pulse
//   per qualified match, and keeps a saturating event count with a sticky
//   overflow flag for status readback.
// PARAMETERS
//   STABLE_CYCLES  4  consecutive cycles needed to qualify/release; legal 1..255
//   CNT_W          8  width of event counter CNT; legal 1..32
// PORTS
//   CP       in   1      clock; all state changes on its rising edge
//   RST      in   1      reset, synchronous, active-high
//   EN       in   1      qualifier enable; 0 = force IDLE (see below)
//   ZN       in   1      active-low match from the 8-input NAND (0 = all ones)
//   CLR_CNT  in   1      synchronous clear of CNT and OVF
//   MATCH    out  1      qualified match level (registered)
//   RISE     out  1      one-cycle pulse on MATCH 0->1 (registered)
//   CNT      out  CNT_W  number of qualified matches, saturating
//   OVF      out  1      sticky: a RISE occurred while CNT was all-ones
// BEHAVIOUR
//   - Input stage: hit_q <= ~ZN on every edge (including EN=0); FSM uses hit_q only.
//   - Stability counter stab, width $clog2(STABLE_CYCLES+1), counts consecutive
//     qualifying cycles; cleared on every state change.
//   - States: IDLE, ARM, MATCHED, RELEASE. MATCH=1 in MATCHED and RELEASE only.
//   - IDLE:    hit_q=1 -> ARM, stab=1 (STABLE_CYCLES=1: -> MATCHED directly).
//   - ARM:     hit_q=0 -> IDLE; hit_q=1 and stab==STABLE_CYCLES-1 -> MATCHED,
//              RISE=1 that cycle; else stab+1.
//   - MATCHED: hit_q=0 -> RELEASE, stab=1 (STABLE_CYCLES=1: -> IDLE directly).
//   - RELEASE: hit_q=1 -> MATCHED, no RISE; hit_q=0 and stab==STABLE_CYCLES-1
//              -> IDLE; else stab+1.
//   - Latency: ZN first sampled low at edge k, held low -> MATCH and RISE high
//     after edge k+STABLE_CYCLES. Release likewise STABLE_CYCLES edges after
//     first low hit_q. Any glitch shorter than STABLE_CYCLES leaves MATCH unchanged.
//   - RISE is high for exactly one cycle per IDLE/ARM -> MATCHED transition.
//   - CNT: +1 on each edge where RISE is being set; at all-ones holds value
//     and sets OVF. OVF stays 1 until CLR_CNT or RST.
//   - CLR_CNT and new RISE in same cycle: CNT=1, OVF=0 (clear, then count).
//   - EN=0: next edge forces IDLE, stab=0, MATCH=0, RISE=0; CNT/OVF hold.
//     EN is reasserted: qualification restarts from IDLE.
//   - RST=1 (any state, mid-qualification included): next edge sets state=IDLE,
//     stab=0, hit_q=0, MATCH=0, RISE=0, CNT=0, OVF=0. RST dominates EN, CLR_CNT.
//   - All outputs registered; no combinational path from input to output.
// TESTING
//   1. RST 2 cycles, ZN=1 -> MATCH=0, RISE=0, CNT=0, OVF=0 on every cycle.
//   2. STABLE_CYCLES=4, ZN=0 sampled at edge 10, held -> MATCH and RISE high
//      after edge 14, RISE low after edge 15, CNT=1.
//   3. ZN low 3 cycles, high 1, low 3 -> MATCH never asserts, CNT stays 0;
//      while MATCHED, ZN high 3 cycles -> MATCH stays 1, no second RISE.
//   4. CNT_W=2: 4 qualified matches -> CNT=3, OVF=1; CLR_CNT coinciding with
//      5th RISE -> CNT=1, OVF=0.
//   5. EN=0 during ARM with stab=2 -> IDLE next edge, MATCH=0; EN back to 1
//      with ZN low -> full 4-cycle qualification again.
//   6. RST while MATCHED with CNT=2 -> all outputs 0 after next edge, even if
//      ZN stays low; qualification restarts once RST drops.

Source files
------------

// File: rtl/gtech_nand8_match_qual_if.sv
// Handshake bundle between the NAND8 match qualifier and its user:
// qualifier controls in, qualified status out.
interface gtech_nand8_match_qual_if #(
    parameter int CNT_W = 8
);
    logic             EN;
    logic             ZN;
    logic             CLR_CNT;
    logic             MATCH;
    logic             RISE;
    logic [CNT_W-1:0] CNT;
    logic             OVF;

    modport master (
        output EN, ZN, CLR_CNT,
        input  MATCH, RISE, CNT, OVF
    );

    modport slave (
        input  EN, ZN, CLR_CNT,
        output MATCH, RISE, CNT, OVF
    );
endinterface

// File: rtl/gtech_nand8_match_qual.sv
// Debounced qualifier for the active-low output of an 8-input NAND: symmetric
// STABLE_CYCLES assert/release filter, one-cycle RISE pulse, saturating event count.
module gtech_nand8_match_qual #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                           CP,
    input  logic                           RST,
    gtech_nand8_match_qual_if.slave        bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_ONE  = SW'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_MATCHED = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic             hit_q;
    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic             match_q, match_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        stab_d  = stab_q;
        if (!bus.EN) begin
            state_d = S_IDLE;
            stab_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit_q) begin
                        if (STABLE_CYCLES == 1) begin
                            state_d = S_MATCHED;
                            stab_d  = '0;
                        end else begin
                            state_d = S_ARM;
                            stab_d  = STAB_ONE;
                        end
                    end
                end
                S_ARM: begin
                    if (!hit_q) begin
                        state_d = S_IDLE;
                        stab_d  = '0;
                    end else if (stab_q == STAB_LAST) begin
                        state_d = S_MATCHED;
                        stab_d  = '0;
                    end else begin
                        stab_d  = stab_q + STAB_ONE;
                    end
                end
                S_MATCHED: begin
                    if (!hit_q) begin
                        if (STABLE_CYCLES == 1) begin
                            state_d = S_IDLE;
                            stab_d  = '0;
                        end else begin
                            state_d = S_RELEASE;
                            stab_d  = STAB_ONE;
                        end
                    end
                end
                S_RELEASE: begin
                    // A returning hit re-enters MATCHED without a new RISE.
                    if (hit_q) begin
                        state_d = S_MATCHED;
                        stab_d  = '0;
                    end else if (stab_q == STAB_LAST) begin
                        state_d = S_IDLE;
                        stab_d  = '0;
                    end else begin
                        stab_d  = stab_q + STAB_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    stab_d  = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        match_d = (state_d == S_MATCHED) || (state_d == S_RELEASE);
        rise_d  = (state_d == S_MATCHED) &&
                  ((state_q == S_IDLE) || (state_q == S_ARM));
    end

    // Clear first, then count, so a coincident clear and RISE leaves CNT=1.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (bus.CLR_CNT) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
        if (rise_d) begin
            if (&cnt_d) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            hit_q   <= 1'b0;
            state_q <= S_IDLE;
            stab_q  <= '0;
            match_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            hit_q   <= ~bus.ZN;
            state_q <= state_d;
            stab_q  <= stab_d;
            match_q <= match_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.MATCH = match_q;
    assign bus.RISE  = rise_q;
    assign bus.CNT   = cnt_q;
    assign bus.OVF   = ovf_q;
endmodule

// File: tb/tb_gtech_nand8_match_qual.sv
// Directed bench: an 8-bit-counter and a 2-bit-counter qualifier share one
// stimulus stream; expected values are hand-derived per step.
module tb_gtech_nand8_match_qual;
    logic CP;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    gtech_nand8_match_qual_if #(.CNT_W(8)) bus8 ();
    gtech_nand8_match_qual_if #(.CNT_W(2)) bus2 ();

    assign bus2.EN      = bus8.EN;
    assign bus2.ZN      = bus8.ZN;
    assign bus2.CLR_CNT = bus8.CLR_CNT;

    gtech_nand8_match_qual #(.STABLE_CYCLES(4), .CNT_W(8)) dut8 (
        .CP  (CP),
        .RST (RST),
        .bus (bus8)
    );

    gtech_nand8_match_qual #(.STABLE_CYCLES(4), .CNT_W(2)) dut2 (
        .CP  (CP),
        .RST (RST),
        .bus (bus2)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic m, input logic r,
                           input logic [7:0] c8, input logic [1:0] c2, input logic o2);
        chk({tag, "_match"}, 32'(bus8.MATCH), 32'(m));
        chk({tag, "_rise"},  32'(bus8.RISE),  32'(r));
        chk({tag, "_cnt8"},  32'(bus8.CNT),   32'(c8));
        chk({tag, "_ovf8"},  32'(bus8.OVF),   32'd0);
        chk({tag, "_cnt2"},  32'(bus2.CNT),   32'(c2));
        chk({tag, "_ovf2"},  32'(bus2.OVF),   32'(o2));
    endtask

    // From IDLE with hit_q=0: four non-matching edges, RISE on the fifth.
    task automatic qual(input string tag, input logic clr, input logic [7:0] c8,
                        input logic [1:0] c2, input logic o2);
        bus8.ZN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, "_arm"}, 32'(bus8.MATCH), 32'd0);
        end
        bus8.CLR_CNT = clr;
        tick();
        bus8.CLR_CNT = 1'b0;
        chk_all(tag, 1'b1, 1'b1, c8, c2, o2);
    endtask

    // From MATCHED with hit_q=1: MATCH holds four edges, drops on the fifth.
    task automatic rel(input string tag, input logic [7:0] c8,
                       input logic [1:0] c2, input logic o2);
        bus8.ZN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, "_hold"}, 32'(bus8.MATCH), 32'd1);
        end
        tick();
        chk_all(tag, 1'b0, 1'b0, c8, c2, o2);
    endtask

    initial begin
        RST          = 1'b1;
        bus8.EN      = 1'b1;
        bus8.ZN      = 1'b1;
        bus8.CLR_CNT = 1'b0;

        // Reset held two cycles.
        tick();
        chk_all("rst1", 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
        tick();
        chk_all("rst2", 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("idle", 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
        end

        // Basic qualification latency.
        bus8.ZN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("t2_arm", 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
        end
        tick();
        chk_all("t2_rise", 1'b1, 1'b1, 8'd1, 2'd1, 1'b0);
        tick();
        chk_all("t2_hold", 1'b1, 1'b0, 8'd1, 2'd1, 1'b0);

        // Three-cycle dropout while matched is filtered, no second RISE.
        bus8.ZN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("t3_drop", 1'b1, 1'b0, 8'd1, 2'd1, 1'b0);
        end
        bus8.ZN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("t3_back", 1'b1, 1'b0, 8'd1, 2'd1, 1'b0);
        end
        rel("t3_rel", 8'd1, 2'd1, 1'b0);

        // Short low bursts never qualify.
        bus8.ZN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("t3_burst_a", 1'b0, 1'b0, 8'd1, 2'd1, 1'b0);
        end
        bus8.ZN = 1'b1;
        tick();
        chk_all("t3_gap", 1'b0, 1'b0, 8'd1, 2'd1, 1'b0);
        bus8.ZN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("t3_burst_b", 1'b0, 1'b0, 8'd1, 2'd1, 1'b0);
        end
        bus8.ZN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("t3_tail", 1'b0, 1'b0, 8'd1, 2'd1, 1'b0);
        end

        // EN drop in ARM (stab=2), then full requalification.
        bus8.ZN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("t5_arm", 1'b0, 1'b0, 8'd1, 2'd1, 1'b0);
        end
        bus8.EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("t5_en_off", 1'b0, 1'b0, 8'd1, 2'd1, 1'b0);
        end
        bus8.EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("t5_rearm", 1'b0, 1'b0, 8'd1, 2'd1, 1'b0);
        end
        tick();
        chk_all("t5_rise", 1'b1, 1'b1, 8'd2, 2'd2, 1'b0);

        // Reset while matched with CNT=2, ZN kept low.
        RST = 1'b1;
        tick();
        chk_all("t6_rst1", 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
        tick();
        chk_all("t6_rst2", 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("t6_arm", 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
        end
        tick();
        chk_all("t6_rise", 1'b1, 1'b1, 8'd1, 2'd1, 1'b0);
        rel("t6_rel", 8'd1, 2'd1, 1'b0);

        // Saturation of the 2-bit counter, sticky OVF, clear coinciding with RISE.
        qual("t4_m2", 1'b0, 8'd2, 2'd2, 1'b0);
        rel("t4_r2", 8'd2, 2'd2, 1'b0);
        qual("t4_m3", 1'b0, 8'd3, 2'd3, 1'b0);
        rel("t4_r3", 8'd3, 2'd3, 1'b0);
        qual("t4_m4", 1'b0, 8'd4, 2'd3, 1'b1);
        rel("t4_r4", 8'd4, 2'd3, 1'b1);
        qual("t4_clr_rise", 1'b1, 8'd1, 2'd1, 1'b0);
        rel("t4_r5", 8'd1, 2'd1, 1'b0);

        // Clear alone.
        bus8.CLR_CNT = 1'b1;
        tick();
        bus8.CLR_CNT = 1'b0;
        chk_all("clr_only", 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
